otbn_rf_bignum_scrub: RTL and testbench
=======================================

# otbn_rf_bignum_scrub

Parametrised wide-register file with per-32-bit-granule (39,32) inverted-Hsiao integrity, one write port, two read ports, a secure-wipe sequencer and a background integrity scrubber. It sits in the OTBN bignum datapath in place of a fixed 32x256b register file. It adds two things: bulk randomised clearing of all registers on request, and periodic re-checking of registers that are not being read.

## Interface
Parameters:
- NumRegs, 32: register count; power of two, >= 2. AddrW = $clog2(NumRegs).
- NumGranules, 8: 32-bit granules per register. W = 32*NumGranules; EW = 39*NumGranules.
- ScrubPeriod, 16: cycles between scrub checks; >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- wr_en_i  in  NumGranules  per-granule write enable.
- wr_addr_i  in  AddrW  write address.
- wr_data_no_intg_i  in  W  write data; the block encodes integrity for it.
- wr_data_intg_i  in  EW  write data with integrity already attached.
- wr_data_intg_sel_i  in  1  selects the write source: 1 = wr_data_intg_i, 0 = encoded wr_data_no_intg_i.
- rd_en_a_i / rd_en_b_i  in  1  read-port enables; they only gate error reporting.
- rd_addr_a_i / rd_addr_b_i  in  AddrW  read addresses.
- rd_data_a_intg_o / rd_data_b_intg_o  out  EW  read data with integrity.
- rd_data_err_o  out  1  integrity error on an enabled read port.
- wipe_req_i  in  1  one-cycle wipe request.
- urnd_i  in  W  random data used for wipe.
- wipe_busy_o  out  1  high while wipe is in progress.
- wipe_done_o  out  1  one-cycle pulse when wipe completes.
- scrub_en_i  in  1  enables the background scrubber.
- scrub_err_o  out  1  sticky flag: the scrubber found an integrity error.
- scrub_err_addr_o  out  AddrW  address of the first scrub error.

## Operation
- Storage: NumRegs x EW flops. On reset, every granule holds the valid codeword for data 0.
- Reads: combinational from the flops. Each granule of each port is decoded for error detection only; no correction is applied.
- rd_data_err_o = (any granule error on A & rd_en_a_i) | (any granule error on B & rd_en_b_i).
- Writes in Idle: every granule with wr_en_i[g] set is written with the mux output for that granule. Other granules are unchanged.
- Main FSM has two states: Idle and Wipe.
  - Idle -> Wipe when wipe_req_i=1. The wipe counter is loaded with 0.
  - In Wipe, each cycle register[counter] gets all granules encoded from urnd_i, then the counter increments.
  - After writing register NumRegs-1, the FSM returns to Idle.
- wipe_busy_o = (state == Wipe).
- wipe_done_o pulses on the first Idle cycle after Wipe.
- wipe_req_i while in Wipe is ignored; the wipe does not restart.
- External writes while in Wipe are dropped.
- Scrubber:
  - Period counter counts 0..ScrubPeriod-1 while scrub_en_i=1 and state==Idle; it holds its value otherwise.
  - At terminal count (tick), all granules of register[scrub_ptr] are decoded.
  - Any error sets scrub_err_o. If scrub_err_o was previously 0, scrub_err_addr_o latches scrub_ptr.
  - scrub_ptr increments on each tick and wraps NumRegs-1 -> 0.
- scrub_err_o stays set until reset; a wipe does not clear it.
- Tick coinciding with a write to the same register: the pre-write (stored) value is checked.

## Timing
- Reset values:
  - rd_data_*_intg_o = codewords of 0.
  - rd_data_err_o = 0.
  - wipe_busy_o = 0, wipe_done_o = 0.
  - scrub_err_o = 0, scrub_err_addr_o = 0.
  - FSM = Idle, scrub_ptr = 0, period counter = 0.
- Write latency: 1 cycle. A read of the same address in the write cycle returns the old data.
- Wipe: request at cycle T; wipe_busy_o is high T+1..T+NumRegs; wipe_done_o pulses at T+NumRegs+1. External writes are accepted again from T+NumRegs+1.
- A wipe_req_i in the cycle wipe_done_o is high starts a new wipe.
- First scrub tick occurs ScrubPeriod cycles after scrub_en_i rises from reset state.
- scrub_err_o asserts one cycle after the faulty tick.
- Reset asserted mid-wipe: immediate return to Idle with all registers at zero codewords; wipe_done_o is not pulsed.

## Test plan
- Reset, then read all 32 registers on both ports with rd_en=1 -> data = zero codewords; rd_data_err_o=0.
- Write 0x0123...CDEF to r5 with wr_en_i=8'h0F and sel=0 -> next cycle, granules 0..3 hold the encoded new data and granules 4..7 are unchanged; a same-cycle read returns the old value.
- Write wr_data_intg_i to r7 with one flipped bit, sel=1 -> reading r7 with rd_en_a_i=1 gives rd_data_err_o=1; with rd_en_a_i=0 it gives 0.
- wipe_req_i at T with urnd_i=0xA5..A5 -> busy T+1..T+32, done pulse at T+33; every register reads encode(0xA5..A5); a write issued at T+5 is dropped.
- Corrupt r3 via sel=1 write, scrub_en_i=1, ScrubPeriod=16 -> at the 4th tick scrub_err_o=1 and scrub_err_addr_o=3; a later corrupt r9 leaves the address at 3.
- Assert rst_i at T+10 of a wipe -> outputs immediately return to reset values; no wipe_done_o pulse.

Source files
------------

// File: rtl/otbn_rf_bignum_scrub.sv
// otbn_rf_bignum_scrub
//   Wide register file for the bignum datapath. Each register holds
//   NumGranules 32-bit granules, and each granule carries a (39,32)
//   inverted-Hsiao codeword. Granule g sits at bits [39g+38:39g], with the
//   data in the low 32 bits and the check bits in the top 7 bits.
//   The block also provides:
//   - a secure-wipe sequencer that fills every register with codewords built
//     from urnd_i, one register per cycle;
//   - a background scrubber that periodically re-checks one register.
//
// Ports
//   clk_i, rst_i           clock, async active-high reset
//   wr_*                   one write port, per-granule enables, two data sources
//   rd_*                   two combinational read ports, shared error flag
//   wipe_*, urnd_i         wipe request/status, random fill data
//   scrub_*                scrubber enable, sticky error flag and address
//
// Main FSM
//   state  | meaning
//   Idle   | normal operation; external writes accepted; scrubber may run
//   Wipe   | register[wipe_cnt] <- encode(urnd_i) each cycle; writes dropped
module otbn_rf_bignum_scrub #(
  parameter int unsigned NumRegs     = 32,
  parameter int unsigned NumGranules = 8,
  parameter int unsigned ScrubPeriod = 16,
  localparam int unsigned AddrW = $clog2(NumRegs),
  localparam int unsigned W     = 32 * NumGranules,
  localparam int unsigned EW    = 39 * NumGranules
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumGranules-1:0] wr_en_i,
  input  logic [AddrW-1:0]       wr_addr_i,
  input  logic [W-1:0]           wr_data_no_intg_i,
  input  logic [EW-1:0]          wr_data_intg_i,
  input  logic                   wr_data_intg_sel_i,
  input  logic                   rd_en_a_i,
  input  logic [AddrW-1:0]       rd_addr_a_i,
  output logic [EW-1:0]          rd_data_a_intg_o,
  input  logic                   rd_en_b_i,
  input  logic [AddrW-1:0]       rd_addr_b_i,
  output logic [EW-1:0]          rd_data_b_intg_o,
  output logic                   rd_data_err_o,
  input  logic                   wipe_req_i,
  input  logic [W-1:0]           urnd_i,
  output logic                   wipe_busy_o,
  output logic                   wipe_done_o,
  input  logic                   scrub_en_i,
  output logic                   scrub_err_o,
  output logic [AddrW-1:0]       scrub_err_addr_o
);

  localparam int unsigned      PerW    = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;
  localparam logic [PerW-1:0]  PerMax  = PerW'(ScrubPeriod - 1);
  localparam logic [AddrW-1:0] LastReg = AddrW'(NumRegs - 1);
  // Codeword of data 0: the inversion constant leaves check bits 0x2A.
  localparam logic [38:0]      ZeroCw  = 39'h2A_0000_0000;

  typedef enum logic {StIdle, StWipe} state_e;

  function automatic logic [38:0] enc39(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606BD25);
    c[1] = ^(d & 32'hDEBA8050);
    c[2] = ^(d & 32'h413D89AA);
    c[3] = ^(d & 32'h31234ED1);
    c[4] = ^(d & 32'hC2C1323B);
    c[5] = ^(d & 32'h2DCC624C);
    c[6] = ^(d & 32'h98505586);
    return {c ^ 7'h2A, d};
  endfunction

  // Detection only: a granule is bad when its check bits disagree with the
  // check bits recomputed from its data bits (non-zero syndrome).
  function automatic logic cw_err(input logic [38:0] cw);
    return cw != enc39(cw[31:0]);
  endfunction

  logic [EW-1:0]    rf_q [NumRegs];
  logic [EW-1:0]    rf_d [NumRegs];
  state_e           state_q, state_d;
  logic [AddrW-1:0] wipe_cnt_q, wipe_cnt_d;
  logic             wipe_done_q, wipe_done_d;
  logic [PerW-1:0]  per_q, per_d;
  logic [AddrW-1:0] scrub_ptr_q, scrub_ptr_d;
  logic             scrub_err_q, scrub_err_d;
  logic [AddrW-1:0] scrub_addr_q, scrub_addr_d;

  logic [EW-1:0] wr_mux;
  logic [EW-1:0] urnd_enc;
  logic          rd_err_a, rd_err_b, scrub_hit, scrub_tick;

  always_comb begin
    wr_mux    = '0;
    urnd_enc  = '0;
    rd_err_a  = 1'b0;
    rd_err_b  = 1'b0;
    scrub_hit = 1'b0;
    for (int unsigned g = 0; g < NumGranules; g++) begin
      wr_mux[g*39 +: 39]   = wr_data_intg_sel_i ? wr_data_intg_i[g*39 +: 39]
                                                : enc39(wr_data_no_intg_i[g*32 +: 32]);
      urnd_enc[g*39 +: 39] = enc39(urnd_i[g*32 +: 32]);
      rd_err_a  = rd_err_a  | cw_err(rf_q[rd_addr_a_i][g*39 +: 39]);
      rd_err_b  = rd_err_b  | cw_err(rf_q[rd_addr_b_i][g*39 +: 39]);
      scrub_hit = scrub_hit | cw_err(rf_q[scrub_ptr_q][g*39 +: 39]);
    end
  end

  always_comb begin
    rf_d        = rf_q;
    state_d     = state_q;
    wipe_cnt_d  = wipe_cnt_q;
    wipe_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int unsigned g = 0; g < NumGranules; g++) begin
          if (wr_en_i[g]) rf_d[wr_addr_i][g*39 +: 39] = wr_mux[g*39 +: 39];
        end
        if (wipe_req_i) begin
          state_d    = StWipe;
          wipe_cnt_d = '0;
        end
      end
      StWipe: begin
        rf_d[wipe_cnt_q] = urnd_enc;
        wipe_cnt_d       = wipe_cnt_q + 1'b1;
        if (wipe_cnt_q == LastReg) begin
          state_d     = StIdle;
          wipe_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The scrubber only advances in Idle so it never races the wipe writes.
  // It checks the stored value, so a same-cycle write to the scrubbed
  // register does not mask an error already present.
  always_comb begin
    scrub_tick   = scrub_en_i && (state_q == StIdle) && (per_q == PerMax);
    per_d        = per_q;
    scrub_ptr_d  = scrub_ptr_q;
    scrub_err_d  = scrub_err_q;
    scrub_addr_d = scrub_addr_q;
    if (scrub_en_i && (state_q == StIdle)) begin
      per_d = (per_q == PerMax) ? '0 : per_q + 1'b1;
    end
    if (scrub_tick) begin
      scrub_ptr_d = scrub_ptr_q + 1'b1;
      if (scrub_hit) begin
        scrub_err_d = 1'b1;
        if (!scrub_err_q) scrub_addr_d = scrub_ptr_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumRegs; i++) rf_q[i] <= {NumGranules{ZeroCw}};
      state_q      <= StIdle;
      wipe_cnt_q   <= '0;
      wipe_done_q  <= 1'b0;
      per_q        <= '0;
      scrub_ptr_q  <= '0;
      scrub_err_q  <= 1'b0;
      scrub_addr_q <= '0;
    end else begin
      rf_q         <= rf_d;
      state_q      <= state_d;
      wipe_cnt_q   <= wipe_cnt_d;
      wipe_done_q  <= wipe_done_d;
      per_q        <= per_d;
      scrub_ptr_q  <= scrub_ptr_d;
      scrub_err_q  <= scrub_err_d;
      scrub_addr_q <= scrub_addr_d;
    end
  end

  assign rd_data_a_intg_o = rf_q[rd_addr_a_i];
  assign rd_data_b_intg_o = rf_q[rd_addr_b_i];
  assign rd_data_err_o    = (rd_err_a & rd_en_a_i) | (rd_err_b & rd_en_b_i);
  assign wipe_busy_o      = (state_q == StWipe);
  assign wipe_done_o      = wipe_done_q;
  assign scrub_err_o      = scrub_err_q;
  assign scrub_err_addr_o = scrub_addr_q;

endmodule

// File: tb/tb_otbn_rf_bignum_scrub.sv
module tb_otbn_rf_bignum_scrub;
  localparam int NR = 32;
  localparam int NG = 8;
  localparam int W  = 256;
  localparam int EW = 312;
  localparam int AW = 5;
  localparam logic [38:0] ZCW  = 39'h2A_0000_0000;  // encode(0x00000000)
  localparam logic [38:0] A5CW = 39'h40_A5A5_A5A5;  // encode(0xA5A5A5A5), hand-derived

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NG-1:0] wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [W-1:0]  wr_data_no_intg_i;
  logic [EW-1:0] wr_data_intg_i;
  logic          wr_data_intg_sel_i;
  logic          rd_en_a_i, rd_en_b_i;
  logic [AW-1:0] rd_addr_a_i, rd_addr_b_i;
  logic [EW-1:0] rd_data_a_intg_o, rd_data_b_intg_o;
  logic          rd_data_err_o;
  logic          wipe_req_i;
  logic [W-1:0]  urnd_i;
  logic          wipe_busy_o, wipe_done_o;
  logic          scrub_en_i;
  logic          scrub_err_o;
  logic [AW-1:0] scrub_err_addr_o;

  otbn_rf_bignum_scrub dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_no_intg_i(wr_data_no_intg_i), .wr_data_intg_i(wr_data_intg_i),
    .wr_data_intg_sel_i(wr_data_intg_sel_i),
    .rd_en_a_i(rd_en_a_i), .rd_addr_a_i(rd_addr_a_i), .rd_data_a_intg_o(rd_data_a_intg_o),
    .rd_en_b_i(rd_en_b_i), .rd_addr_b_i(rd_addr_b_i), .rd_data_b_intg_o(rd_data_b_intg_o),
    .rd_data_err_o(rd_data_err_o),
    .wipe_req_i(wipe_req_i), .urnd_i(urnd_i),
    .wipe_busy_o(wipe_busy_o), .wipe_done_o(wipe_done_o),
    .scrub_en_i(scrub_en_i), .scrub_err_o(scrub_err_o), .scrub_err_addr_o(scrub_err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] shadow [NR];

  typedef struct {
    logic [NG-1:0] wr_en;
    logic [AW-1:0] wr_addr;
    logic          sel;
    logic [W-1:0]  d_no;
    logic [EW-1:0] d_intg;
    logic [AW-1:0] ra;
    logic          ea;
    logic [AW-1:0] rb;
    logic          eb;
    logic          exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [31:0] m [7];
    logic [6:0]  c;
    m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
          32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
    for (int k = 0; k < 7; k++) c[k] = ^(d & m[k]);
    return {c ^ 7'h2A, d};
  endfunction

  function automatic logic [EW-1:0] fill(input logic [38:0] cw);
    logic [EW-1:0] r;
    for (int g = 0; g < NG; g++) r[g*39 +: 39] = cw;
    return r;
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic read_all(input logic [EW-1:0] exp, input string tag);
    wr_en_i   = '0;
    rd_en_a_i = 1'b1;
    rd_en_b_i = 1'b1;
    for (int i = 0; i < NR; i++) begin
      rd_addr_a_i = AW'(i);
      rd_addr_b_i = AW'(NR - 1 - i);
      #1;
      chk($sformatf("%s_a_r%0d", tag, i), rd_data_a_intg_o, exp);
      chk($sformatf("%s_b_r%0d", tag, NR - 1 - i), rd_data_b_intg_o, exp);
      chk($sformatf("%s_err_r%0d", tag, i), rd_data_err_o, 1'b0);
    end
  endtask

  initial begin
    logic [EW-1:0] c7, c31, bad3, bad9;
    logic [W-1:0]  pat;
    logic          saw_done;

    rst_i = 1'b1;
    wr_en_i = '0; wr_addr_i = '0; wr_data_no_intg_i = '0; wr_data_intg_i = '0;
    wr_data_intg_sel_i = 1'b0; rd_en_a_i = 1'b1; rd_en_b_i = 1'b1;
    rd_addr_a_i = '0; rd_addr_b_i = '0; wipe_req_i = 1'b0; urnd_i = '0; scrub_en_i = 1'b0;
    for (int i = 0; i < NR; i++) shadow[i] = fill(ZCW);

    pat = {4{64'h0123456789ABCDEF}};
    c7  = fill(ZCW) ^ (EW'(1) << (2*39 + 3));
    c31 = fill(enc(32'hDEADBEEF));
    vecs[0] = '{8'h0F, 5'd5,  1'b0, pat,              '0,  5'd5,  1'b1, 5'd0,  1'b1, 1'b0};
    vecs[1] = '{8'hF0, 5'd5,  1'b0, {8{32'hFFFFFFFF}}, '0,  5'd5,  1'b1, 5'd5,  1'b1, 1'b0};
    vecs[2] = '{8'hFF, 5'd7,  1'b1, pat,              c7,  5'd7,  1'b1, 5'd0,  1'b0, 1'b1};
    vecs[3] = '{8'h00, 5'd7,  1'b0, pat,              '0,  5'd7,  1'b0, 5'd7,  1'b0, 1'b0};
    vecs[4] = '{8'h00, 5'd7,  1'b0, pat,              '0,  5'd0,  1'b0, 5'd7,  1'b1, 1'b1};
    vecs[5] = '{8'hFF, 5'd7,  1'b0, {8{32'h13579BDF}}, '0,  5'd7,  1'b1, 5'd7,  1'b1, 1'b0};
    vecs[6] = '{8'h81, 5'd31, 1'b1, pat,              c31, 5'd31, 1'b1, 5'd5,  1'b1, 1'b0};
    vecs[7] = '{8'h00, 5'd0,  1'b0, pat,              '0,  5'd0,  1'b1, 5'd31, 1'b1, 1'b0};

    // Reset values while reset is held
    #3;
    chk("rst_busy", wipe_busy_o, 1'b0);
    chk("rst_done", wipe_done_o, 1'b0);
    chk("rst_scrub_err", scrub_err_o, 1'b0);
    chk("rst_scrub_addr", scrub_err_addr_o, '0);
    chk("rst_rd_a", rd_data_a_intg_o, fill(ZCW));
    chk("rst_rd_err", rd_data_err_o, 1'b0);
    step(); step();
    rst_i = 1'b0;
    step();
    read_all(fill(ZCW), "rst");

    // Table-driven writes and reads
    step();
    for (int i = 0; i < 8; i++) begin
      wr_en_i = vecs[i].wr_en; wr_addr_i = vecs[i].wr_addr; wr_data_intg_sel_i = vecs[i].sel;
      wr_data_no_intg_i = vecs[i].d_no; wr_data_intg_i = vecs[i].d_intg;
      rd_addr_a_i = vecs[i].ra; rd_en_a_i = vecs[i].ea;
      rd_addr_b_i = vecs[i].rb; rd_en_b_i = vecs[i].eb;
      #1;
      chk($sformatf("v%0d_old_a", i), rd_data_a_intg_o, shadow[vecs[i].ra]);
      chk($sformatf("v%0d_old_b", i), rd_data_b_intg_o, shadow[vecs[i].rb]);
      for (int g = 0; g < NG; g++)
        if (vecs[i].wr_en[g])
          shadow[vecs[i].wr_addr][g*39 +: 39] = vecs[i].sel ? vecs[i].d_intg[g*39 +: 39]
                                                            : enc(vecs[i].d_no[g*32 +: 32]);
      step();
      wr_en_i = '0;
      #1;
      chk($sformatf("v%0d_new_a", i), rd_data_a_intg_o, shadow[vecs[i].ra]);
      chk($sformatf("v%0d_new_b", i), rd_data_b_intg_o, shadow[vecs[i].rb]);
      chk($sformatf("v%0d_err", i), rd_data_err_o, vecs[i].exp_err);
    end

    // Wipe: request at T, busy T+1..T+32, done at T+33
    step();
    urnd_i = {32{8'hA5}};
    wipe_req_i = 1'b1;
    #1;
    chk("wipe_T_busy", wipe_busy_o, 1'b0);
    step();
    wipe_req_i = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      wipe_req_i = (k == 1);            // re-request mid-wipe must be ignored
      if (k == 5) begin                 // r2 already wiped; this write must be dropped
        wr_en_i = '1; wr_addr_i = 5'd2; wr_data_intg_sel_i = 1'b0; wr_data_no_intg_i = '0;
      end else begin
        wr_en_i = '0;
      end
      #1;
      chk($sformatf("wipe_busy_T%0d", k), wipe_busy_o, 1'b1);
      chk($sformatf("wipe_done_T%0d", k), wipe_done_o, 1'b0);
      step();
    end
    wr_en_i = '0;
    wipe_req_i = 1'b1;                  // request in the done cycle starts a new wipe
    #1;
    chk("wipe_T33_done", wipe_done_o, 1'b1);
    chk("wipe_T33_busy", wipe_busy_o, 1'b0);
    step();
    wipe_req_i = 1'b0;
    #1;
    chk("wipe2_T1_busy", wipe_busy_o, 1'b1);
    chk("wipe2_T1_done", wipe_done_o, 1'b0);
    for (int k = 2; k <= 32; k++) step();
    chk("wipe2_T32_busy", wipe_busy_o, 1'b1);
    step();
    chk("wipe2_T33_done", wipe_done_o, 1'b1);
    chk("wipe2_T33_busy", wipe_busy_o, 1'b0);
    step();
    chk("wipe2_T34_done", wipe_done_o, 1'b0);
    read_all(fill(A5CW), "wipe");
    for (int i = 0; i < NR; i++) shadow[i] = fill(A5CW);

    // Scrubber: corrupt r3 and r9, then enable
    step();
    bad3 = fill(A5CW) ^ (EW'(1) << 5);
    bad9 = fill(A5CW) ^ (EW'(1) << (4*39 + 38));
    wr_en_i = '1; wr_data_intg_sel_i = 1'b1; wr_addr_i = 5'd3; wr_data_intg_i = bad3;
    step();
    wr_addr_i = 5'd9; wr_data_intg_i = bad9;
    step();
    wr_en_i = '0; wr_data_intg_sel_i = 1'b0;
    scrub_en_i = 1'b1;                  // cycle E
    for (int k = 0; k < 63; k++) begin
      step();
      if (k == 15) chk("scrub_tick1_clean", scrub_err_o, 1'b0);
    end
    chk("scrub_E63_err", scrub_err_o, 1'b0);
    step();
    chk("scrub_E64_err", scrub_err_o, 1'b1);
    chk("scrub_E64_addr", scrub_err_addr_o, 5'd3);
    for (int k = 0; k < 100; k++) step();
    chk("scrub_r9_err", scrub_err_o, 1'b1);
    chk("scrub_r9_addr", scrub_err_addr_o, 5'd3);
    scrub_en_i = 1'b0;

    // Reset in the middle of a wipe
    step();
    urnd_i = {8{32'h5A5A5A5A}};
    wipe_req_i = 1'b1;
    step();
    wipe_req_i = 1'b0;
    for (int k = 2; k <= 10; k++) step();
    rd_addr_a_i = '0; rd_en_a_i = 1'b1;
    #1;
    chk("midwipe_busy", wipe_busy_o, 1'b1);
    chk("midwipe_scrub_err_kept", scrub_err_o, 1'b1);
    chk("midwipe_r0", rd_data_a_intg_o, fill(enc(32'h5A5A5A5A)));
    rst_i = 1'b1;
    #1;
    chk("rstwipe_busy", wipe_busy_o, 1'b0);
    chk("rstwipe_done", wipe_done_o, 1'b0);
    chk("rstwipe_scrub_err", scrub_err_o, 1'b0);
    chk("rstwipe_scrub_addr", scrub_err_addr_o, '0);
    chk("rstwipe_r0", rd_data_a_intg_o, fill(ZCW));
    step(); step();
    rst_i = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      saw_done = saw_done | wipe_done_o;
    end
    chk("rstwipe_no_done", saw_done, 1'b0);
    read_all(fill(ZCW), "rstwipe");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
